// File: rtl/fifo_burst_if.sv
// Handshake and status bundle between the burst sequencer and its surroundings.
// master: the controller side; slave: the sample source / sink / FIFO side.
interface fifo_burst_if #(
    parameter int OCC_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic             out_ready;
    logic             flush;
    logic             fifo_w_en;
    logic             fifo_r_en;
    logic             out_valid;
    logic             out_last;
    logic [OCC_W-1:0] occupancy;
    logic [1:0]       state;
    logic [15:0]      stall_cnt;

    modport master (
        input  in_valid, out_ready, flush,
        output in_ready, fifo_w_en, fifo_r_en, out_valid, out_last,
               occupancy, state, stall_cnt
    );

    modport slave (
        output in_valid, out_ready, flush,
        input  in_ready, fifo_w_en, fifo_r_en, out_valid, out_last,
               occupancy, state, stall_cnt
    );
endinterface

// File: rtl/fifo_burst_ctrl.sv
// Burst sequencer for the circular-buffer sample FIFO.
// Admits samples while filling, releases fixed-length bursts, and discards
// stored samples on flush. Write and read enables are exclusive by state:
// writes only happen in FILL, reads only in BURST/FLUSH.
module fifo_burst_ctrl #(
    parameter int DEPTH     = 32,
    parameter int BURST_LEN = 8,
    parameter int OCC_W     = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    fifo_burst_if.master bus
);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {
        S_FILL  = 2'b00,
        S_BURST = 2'b01,
        S_FLUSH = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic             flush_pend_q, flush_pend_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [15:0]      stall_q, stall_d;

    logic in_ready, w_en, r_en, bcnt_last;

    // Gated by rst_n: the FIFO is held in reset too, so a sample taken now would be lost.
    assign in_ready  = rst_n && (state_q == S_FILL) && (occ_q < OCC_W'(DEPTH)) && !flush_pend_q;
    assign w_en      = bus.in_valid && in_ready;
    assign r_en      = (state_q == S_BURST) || ((state_q == S_FLUSH) && (occ_q != '0));
    assign bcnt_last = (bcnt_q == BW'(BURST_LEN - 1));

    // Next-state, occupancy, burst counter, pending flush and registered output strobes.
    always_comb begin
        state_d      = state_q;
        bcnt_d       = bcnt_q;
        flush_pend_d = flush_pend_q;
        occ_d        = occ_q;
        stall_d      = stall_q;
        if (w_en)
            occ_d = occ_q + 1'b1;
        else if (r_en)
            occ_d = occ_q - 1'b1;
        // FIFO data_out is registered, so the burst strobes trail the read by one cycle.
        out_valid_d = (state_q == S_BURST);
        out_last_d  = (state_q == S_BURST) && bcnt_last;
        if (bus.in_valid && !in_ready && (stall_q != 16'hFFFF))
            stall_d = stall_q + 1'b1;

        case (state_q)
            S_FILL: begin
                if (bus.flush || flush_pend_q) begin
                    state_d      = S_FLUSH;
                    flush_pend_d = 1'b0;
                end else if ((occ_d >= OCC_W'(BURST_LEN)) && bus.out_ready) begin
                    // occ_d so a write accepted this very cycle counts toward the burst
                    state_d = S_BURST;
                    bcnt_d  = '0;
                end
            end
            S_BURST: begin
                // Burst is uninterruptible; a flush request is parked until it ends.
                flush_pend_d = flush_pend_q || bus.flush;
                bcnt_d       = bcnt_q + 1'b1;
                if (bcnt_last) begin
                    bcnt_d = '0;
                    if (flush_pend_q) begin
                        state_d      = S_FLUSH;
                        flush_pend_d = 1'b0;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FLUSH: begin
                flush_pend_d = 1'b0;
                if (occ_q == '0)
                    state_d = S_FILL;
            end
            default: state_d = S_FILL;
        endcase
    end

    // State and status registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FILL;
            occ_q        <= '0;
            bcnt_q       <= '0;
            flush_pend_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            occ_q        <= occ_d;
            bcnt_q       <= bcnt_d;
            flush_pend_q <= flush_pend_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            stall_q      <= stall_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.fifo_w_en = w_en;
    assign bus.fifo_r_en = r_en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.occupancy = occ_q;
    assign bus.state     = state_q;
    assign bus.stall_cnt = stall_q;
endmodule

// File: tb/tb_fifo_burst_ctrl.sv
// Directed + random bench for fifo_burst_ctrl with a small registered-output FIFO model.
module tb_fifo_burst_ctrl;
    localparam int DEPTH = 32;
    localparam int BL    = 8;
    localparam int OCC_W = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] din;
    logic [15:0] dout;
    logic [15:0] mem [DEPTH];
    logic [4:0]  wp, rp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fifo_burst_if #(.OCC_W(OCC_W)) bus();

    fifo_burst_ctrl #(.DEPTH(DEPTH), .BURST_LEN(BL), .OCC_W(OCC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // FIFO storage
    always_ff @(posedge clk) begin
        if (bus.fifo_w_en) mem[wp] <= din;
    end

    // FIFO pointers and registered data output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp   <= '0;
            rp   <= '0;
            dout <= '0;
        end else begin
            if (bus.fifo_w_en) wp <= wp + 1'b1;
            if (bus.fifo_r_en) begin
                dout <= mem[rp];
                rp   <= rp + 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write BL samples base..base+BL-1 with out_ready high, then check the burst.
    task automatic fill_and_burst(input logic [15:0] base);
        bus.out_ready = 1'b1;
        for (int i = 0; i < BL; i++) begin
            bus.in_valid = 1'b1;
            din = base + 16'(i);
            #1;
            chk("fill_wen", 32'(bus.fifo_w_en), 32'd1);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("burst_entry_state", 32'(bus.state), 32'd1);
        chk("burst_entry_occ", 32'(bus.occupancy), 32'd8);
        for (int i = 0; i < BL; i++) begin
            chk("burst_ren", 32'(bus.fifo_r_en), 32'd1);
            chk("burst_wen", 32'(bus.fifo_w_en), 32'd0);
            tick();
            chk("burst_ov", 32'(bus.out_valid), 32'd1);
            chk("burst_data", 32'(dout), 32'(base + 16'(i)));
            chk("burst_last", 32'(bus.out_last), 32'(i == BL - 1));
        end
        chk("burst_end_state", 32'(bus.state), 32'd0);
        chk("burst_end_occ", 32'(bus.occupancy), 32'd0);
        chk("burst_end_ren", 32'(bus.fifo_r_en), 32'd0);
        tick();
        chk("burst_after_ov", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] q[$];
        logic [15:0] exp_d, popped;
        int          exp_occ, run, reads;
        logic        exp_ov, exp_last, nov, nlast;

        // Reset with random inputs
        rst_n = 1'b0;
        din = '0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.flush     = 1'($urandom_range(0, 1));
            din           = 16'($urandom);
            #1;
            chk("rst_ov", 32'(bus.out_valid), 32'd0);
            chk("rst_last", 32'(bus.out_last), 32'd0);
            chk("rst_state", 32'(bus.state), 32'd0);
            chk("rst_occ", 32'(bus.occupancy), 32'd0);
            chk("rst_stall", 32'(bus.stall_cnt), 32'd0);
            chk("rst_wen", 32'(bus.fifo_w_en), 32'd0);
            chk("rst_ren", 32'(bus.fifo_r_en), 32'd0);
            chk("rst_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        rst_n = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.flush = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

        // Basic burst of 1..8
        fill_and_burst(16'h0001);

        // Saturate at DEPTH with the sink stalled
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 40; c++) begin
            din = 16'h0100 + 16'(c);
            #1;
            if (c >= DEPTH) begin
                chk("full_wen", 32'(bus.fifo_w_en), 32'd0);
                chk("full_ready", 32'(bus.in_ready), 32'd0);
            end
            tick();
        end
        chk("full_occ", 32'(bus.occupancy), 32'd32);
        chk("full_ready_end", 32'(bus.in_ready), 32'd0);
        chk("full_stall", 32'(bus.stall_cnt), 32'd8);
        bus.in_valid = 1'b0;

        // Flush from FILL drains all 32 without out_valid
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_state", 32'(bus.state), 32'd2);
        reads = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.state == 2'd0) break;
            if (bus.fifo_r_en) reads++;
            chk("flush_ov", 32'(bus.out_valid), 32'd0);
            tick();
        end
        chk("flush_done_state", 32'(bus.state), 32'd0);
        chk("flush_reads", 32'(reads), 32'd32);
        chk("flush_done_occ", 32'(bus.occupancy), 32'd0);

        // Flush with an empty FIFO lasts one cycle
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("eflush_state", 32'(bus.state), 32'd2);
        chk("eflush_ren", 32'(bus.fifo_r_en), 32'd0);
        tick();
        chk("eflush_back", 32'(bus.state), 32'd0);

        // 12 stored, flush pulse at bcnt=3 of the burst
        bus.out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.in_valid = 1'b1;
            din = 16'h0200 + 16'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        #1;
        chk("f12_occ", 32'(bus.occupancy), 32'd12);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("f12_burst", 32'(bus.state), 32'd1);
        for (int c = 0; c < BL; c++) begin
            bus.flush = (c == 3);
            #1;
            chk("f12_ren", 32'(bus.fifo_r_en), 32'd1);
            tick();
            bus.flush = 1'b0;
            chk("f12_ov", 32'(bus.out_valid), 32'd1);
            chk("f12_data", 32'(dout), 32'(16'h0200 + 16'(c)));
            chk("f12_last", 32'(bus.out_last), 32'(c == BL - 1));
        end
        chk("f12_flush_state", 32'(bus.state), 32'd2);
        chk("f12_flush_occ", 32'(bus.occupancy), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("f12_flush_ren", 32'(bus.fifo_r_en), 32'd1);
            tick();
            chk("f12_flush_ov", 32'(bus.out_valid), 32'd0);
        end
        chk("f12_last_flush", 32'(bus.state), 32'd2);
        chk("f12_last_ren", 32'(bus.fifo_r_en), 32'd0);
        chk("f12_empty", 32'(bus.occupancy), 32'd0);
        tick();
        chk("f12_fill", 32'(bus.state), 32'd0);

        // Reset mid-burst at bcnt=5
        bus.out_ready = 1'b1;
        for (int i = 0; i < BL; i++) begin
            bus.in_valid = 1'b1;
            din = 16'h0300 + 16'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("mr_burst", 32'(bus.state), 32'd1);
        for (int i = 0; i < 5; i++) tick();
        chk("mr_ov_before", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_ov", 32'(bus.out_valid), 32'd0);
        chk("mr_last", 32'(bus.out_last), 32'd0);
        chk("mr_state", 32'(bus.state), 32'd0);
        chk("mr_occ", 32'(bus.occupancy), 32'd0);
        chk("mr_ren", 32'(bus.fifo_r_en), 32'd0);
        chk("mr_stall", 32'(bus.stall_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mr_ready", 32'(bus.in_ready), 32'd1);
        fill_and_burst(16'h0400);

        // Random traffic against a scoreboard
        exp_occ = 0; exp_ov = 1'b0; exp_last = 1'b0; exp_d = '0; run = 0;
        for (int n = 0; n < 10000; n++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) == 0);
            bus.flush     = ($urandom_range(0, 63) == 0);
            din           = 16'($urandom);
            #1;
            chk("rnd_excl", 32'(bus.fifo_w_en & bus.fifo_r_en), 32'd0);
            chk("rnd_occ", 32'(bus.occupancy), 32'(exp_occ));
            chk("rnd_ov", 32'(bus.out_valid), 32'(exp_ov));
            chk("rnd_last", 32'(bus.out_last), 32'(exp_last));
            if (exp_ov) chk("rnd_data", 32'(dout), 32'(exp_d));
            if (bus.state != 2'd1 && run != 0) begin
                chk("rnd_burst_len", 32'(run), 32'(BL));
                run = 0;
            end
            nov = 1'b0;
            nlast = 1'b0;
            if (bus.fifo_w_en) begin
                q.push_back(din);
                exp_occ++;
            end
            if (bus.fifo_r_en) begin
                chk("rnd_rd_avail", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    popped = q.pop_front();
                    exp_occ--;
                    if (bus.state == 2'd1) begin
                        run++;
                        nov   = 1'b1;
                        nlast = (run == BL);
                        exp_d = popped;
                    end
                end
            end
            exp_ov   = nov;
            exp_last = nlast;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
